gcd_param: RTL

Parametrised, key-locked subtractive GCD engine that succeeds the fixed 5-bit `gcd` core. It adds valid/ready handshakes on operands and result, an iteration counter, and an iteration-limit guard that forces termination on locked (wrong-key) or pathological inputs. It sits behind the obfuscation test harness as the reference locked arithmetic unit. The correct key is `KEY_W'b10`: `k[0]=1`, `k[1]=0`.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_step.sv | 27 ++
 rtl/gcd_param.sv | 104 ++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the key-locked GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gcd_state_e;

  localparam logic [1:0] GCD_KEY_CORRECT = 2'b10;

  function automatic int gcd_cnt_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One subtractive GCD step: swap when a<b, else reduce a.
module gcd_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_r,
  input  logic [WIDTH-1:0] b_r,
  input  logic             k1,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             zero
);

  always_comb begin
    zero  = (b_r == '0);
    a_nxt = a_r;
    b_nxt = b_r;
    if (a_r < b_r) begin
      a_nxt = b_r;
      b_nxt = a_r;
    end else if (k1) begin
      a_nxt = a_r + b_r;
    end else begin
      a_nxt = a_r - b_r;
    end
  end

endmodule

// File: rtl/gcd_param.sv
// Key-locked subtractive GCD engine with valid/ready handshakes
// and an iteration-limit guard.
module gcd_param
  import gcd_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 64,
  parameter int KEY_W    = 2,
  localparam int CW      = gcd_cnt_w(MAX_ITER)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:KEY_W-1] k,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    iters,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CW-1:0] LIM  = CW'(MAX_ITER - 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_ITER);

  gcd_state_e       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_d, b_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    iters_q;
  logic             timeout_q;
  logic             zero;
  logic             key_ok;

  // Key literal is MSB-first, so bit 1 of it lines up with k[0].
  assign key_ok = (k[0] == GCD_KEY_CORRECT[1]);

  gcd_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a_r  (a_q),
    .b_r  (b_q),
    .k1   (k[1]),
    .a_nxt(a_d),
    .b_nxt(b_d),
    .zero (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      iters_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= '0;
            if (key_ok) state_q <= RUN;
          end
        end
        RUN: begin
          if (zero) begin
            state_q   <= DONE;
            result_q  <= a_q;
            iters_q   <= cnt_q + 1'b1;
            timeout_q <= 1'b0;
          end else if (cnt_q == LIM) begin
            state_q   <= DONE;
            result_q  <= a_q;
            iters_q   <= FULL;
            timeout_q <= 1'b1;
          end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign iters     = iters_q;
  assign timeout   = timeout_q;

endmodule
